eth_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one Ethernet frame transmitter (start/length in, byte-valid out) among NUM_REQ requesters.
- Selects a requester, validates its payload length, pulses the transmitter start and tracks the frame byte-by-byte via the transmitter's valid.
- Signals completion or error per requester and enforces an inter-frame gap before the next grant.
- Sits between the per-port frame sources and the transmitter; the grant index drives the transmitter's MAC/payload input mux.

---
 rtl/eth_pkg.sv | 26 ++
 rtl/eth_tx_scheduler_rr_arbiter.sv | 36 +++
 rtl/eth_tx_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path.
//   - Frame-size constants (header bytes, minimum frame, maximum payload).
//   - EtherType constant for IPv4.
//   - Scheduler state encoding and a payload-length legality helper.
package eth_pkg;

    localparam int unsigned HDR_BYTES      = 14;    // 2x MAC + EtherType
    localparam int unsigned MIN_FRAME      = 64;
    localparam int unsigned MAX_PAYLOAD    = 1500;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        XMIT  = 3'd3,
        DONE  = 3'd4,
        IFG   = 3'd5
    } state_t;

    // A payload is legal when it is non-empty and no larger than max_len.
    function automatic logic len_ok(input logic [15:0] len, input int unsigned max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : index of the last winner; search starts at ptr+1 and wraps
//   winner : one-hot winning requester (zero when no request)
//   idx    : binary index of the winner
//   any    : at least one request present
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         winner,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IW'((32'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Round-robin scheduler sharing one Ethernet frame transmitter among
// NUM_REQ requesters. Validates payload length, pulses tx_start, counts
// header+payload bytes on tx_valid, reports done/frame_err per frame and
// enforces an inter-frame gap of IFG_CYCLES.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-requester level request
//   req_len    : per-requester payload length, slice i = [16i+15:16i]
//   gnt        : one-hot grant, held for the frame
//   gnt_idx    : binary index of current/last grant
//   tx_start   : one-cycle start pulse to the transmitter
//   tx_length  : payload length presented with tx_start
//   tx_valid   : transmitter byte-valid
//   done       : one-cycle per-requester completion pulse
//   reject     : one-cycle per-requester refusal pulse (bad length)
//   frame_err  : pulses with done when the byte count fell short
//   busy       : high in every state except IDLE
//
// Build option: define FRAME_TIMEOUT_EN to end a frame with frame_err when
// tx_valid does not rise within TIMEOUT_CYCLES cycles of tx_start.
module eth_tx_scheduler
    import eth_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned IFG_CYCLES     = 12,
    parameter int unsigned MAX_PAYLOAD    = eth_pkg::MAX_PAYLOAD,
    parameter int unsigned HDR_BYTES      = eth_pkg::HDR_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*16-1:0]      req_len,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       tx_start,
    output logic [15:0]                tx_length,
    input  logic                       tx_valid,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         reject,
    output logic                       frame_err,
    output logic                       busy
);

    localparam int unsigned IW     = $clog2(NUM_REQ);
    localparam int unsigned CYC_MAX = (IFG_CYCLES > TIMEOUT_CYCLES) ? IFG_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW     = $clog2(CYC_MAX + 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]        gnt_idx_q, gnt_idx_d;
    logic                 tx_start_q, tx_start_d;
    logic [15:0]          tx_length_q, tx_length_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   reject_q, reject_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic [16:0]          count_q, count_d;
    logic [16:0]          exp_q, exp_d;
    // Shared by the IFG gap and the optional WAIT timeout; never live in both.
    logic [CW-1:0]        cyc_q, cyc_d;

    logic [NUM_REQ-1:0]   arb_winner;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;
    logic [15:0]          win_len;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    always_comb begin
        win_len = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                win_len = req_len[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        tx_start_d  = 1'b0;
        tx_length_d = tx_length_q;
        done_d      = '0;
        reject_d    = '0;
        frame_err_d = 1'b0;
        count_d     = count_q;
        exp_d       = exp_q;
        cyc_d       = cyc_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    ptr_d = arb_idx;
                    if (len_ok(win_len, MAX_PAYLOAD)) begin
                        gnt_d       = arb_winner;
                        gnt_idx_d   = arb_idx;
                        tx_length_d = win_len;
                        state_d     = START;
                    end else begin
                        reject_d = arb_winner;
                    end
                end
            end
            START: begin
                // Registered, so the pulse is seen in the first WAIT cycle.
                tx_start_d = 1'b1;
                exp_d      = 17'(HDR_BYTES) + {1'b0, tx_length_q};
                count_d    = '0;
                cyc_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (tx_valid) begin
                    count_d = 17'd1;
                    state_d = XMIT;
                end
`ifdef FRAME_TIMEOUT_EN
                else if (cyc_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = DONE;
                    done_d      = gnt_q;
                    frame_err_d = 1'b1;
                    gnt_d       = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
`endif
            end
            XMIT: begin
                if (tx_valid) begin
                    count_d = count_q + 17'd1;
                    if (count_d == exp_q) begin
                        state_d = DONE;
                        done_d  = gnt_q;
                        gnt_d   = '0;
                    end
                end else begin
                    state_d     = DONE;
                    done_d      = gnt_q;
                    frame_err_d = 1'b1;
                    gnt_d       = '0;
                end
            end
            DONE: begin
                cyc_d   = '0;
                state_d = IFG;
            end
            IFG: begin
                if (cyc_q == CW'(IFG_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(NUM_REQ - 1);
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            tx_start_q  <= 1'b0;
            tx_length_q <= '0;
            done_q      <= '0;
            reject_q    <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
            exp_q       <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            tx_start_q  <= tx_start_d;
            tx_length_q <= tx_length_d;
            done_q      <= done_d;
            reject_q    <= reject_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            exp_q       <= exp_d;
            cyc_q       <= cyc_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign tx_start  = tx_start_q;
    assign tx_length = tx_length_q;
    assign done      = done_q;
    assign reject    = reject_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
module tb_eth_tx_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_len;
    logic [3:0]  gnt;
    logic [1:0]  gnt_idx;
    logic        tx_start;
    logic [15:0] tx_length;
    logic        tx_valid;
    logic [3:0]  done;
    logic [3:0]  reject;
    logic        frame_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    eth_tx_scheduler #(
        .NUM_REQ        (4),
        .IFG_CYCLES     (12),
        .MAX_PAYLOAD    (1500),
        .HDR_BYTES      (14),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .tx_start  (tx_start),
        .tx_length (tx_length),
        .tx_valid  (tx_valid),
        .done      (done),
        .reject    (reject),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int cnt;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 40) begin
            tick();
            cnt++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        req      = '0;
        req_len  = '0;
        tx_valid = 1'b0;
        repeat (2) tick();
        n_tests++;
        if ({gnt, gnt_idx, tx_start, tx_length, done, reject, frame_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b idx=%0d start=%b len=%0d done=%b rej=%b err=%b busy=%b required all 0",
                     gnt, gnt_idx, tx_start, tx_length, done, reject, frame_err, busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_len[15:0] = 16'd10;
        req = 4'b0001;
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || busy !== 1'b1 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_gnt: gnt=%b idx=%0d busy=%b start=%b required 0001/0/1/0", gnt, gnt_idx, busy, tx_start);
        end
        tick();
        n_tests++;
        if (tx_start !== 1'b1 || tx_length !== 16'd10) begin
            n_fail++;
            $display("FAIL single_start: start=%b len=%0d required 1/10", tx_start, tx_length);
        end
        tx_valid = 1'b1;
        repeat (23) tick();
        n_tests++;
        if (done !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_early_done: done=%b after 23 bytes required 0000", done);
        end
        tick();
        tx_valid = 1'b0;
        req = 4'b0000;
        n_tests++;
        if (done !== 4'b0001 || frame_err !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_done: done=%b err=%b gnt=%b required 0001/0/0000", done, frame_err, gnt);
        end
        repeat (12) tick();
        n_tests++;
        if (busy !== 1'b1 || done !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_ifg: busy=%b done=%b at last gap cycle required 1/0000", busy, done);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b 13 cycles after done required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) req_len[16*i +: 16] = 16'd46;
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            cnt = 0;
            while (gnt === 4'b0000 && cnt < 40) begin
                tick();
                cnt++;
            end
            n_tests++;
            if (gnt !== (4'b0001 << (f % 4)) || gnt_idx !== 2'(f % 4)) begin
                n_fail++;
                $display("FAIL rr_order_%0d: gnt=%b idx=%0d required %b/%0d", f, gnt, gnt_idx, 4'b0001 << (f % 4), f % 4);
            end
            if (f > 0) begin
                // DONE cycle, 12 gap cycles, one IDLE evaluation, then grant edge.
                n_tests++;
                if (cnt != 14) begin
                    n_fail++;
                    $display("FAIL rr_gap_%0d: grant %0d cycles after done required 14", f, cnt);
                end
            end
            tick();
            tx_valid = 1'b1;
            repeat (60) tick();
            tx_valid = 1'b0;
            n_tests++;
            if (done !== (4'b0001 << (f % 4)) || frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_done_%0d: done=%b err=%b required %b/0", f, done, frame_err, 4'b0001 << (f % 4));
            end
        end
        req = 4'b0000;
        wait_idle("rr");
    endtask

    task automatic test_bad_length();
        req_len[47:32] = 16'd0;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        n_tests++;
        if (reject !== 4'b0100 || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_len0: reject=%b gnt=%b busy=%b required 0100/0000/0", reject, gnt, busy);
        end
        tick();
        req_len[47:32] = 16'd1501;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        n_tests++;
        if (reject !== 4'b0100 || busy !== 1'b0 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_len1501: reject=%b busy=%b start=%b required 0100/0/0", reject, busy, tx_start);
        end
        tick();
        n_tests++;
        if (reject !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_after: reject=%b start=%b busy=%b required 0000/0/0", reject, tx_start, busy);
        end
        req_len[47:32] = 16'd1500;
        req = 4'b0100;
        tick();
        n_tests++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || reject !== 4'b0000) begin
            n_fail++;
            $display("FAIL max_len_gnt: gnt=%b idx=%0d reject=%b required 0100/2/0000", gnt, gnt_idx, reject);
        end
        tick();
        n_tests++;
        if (tx_start !== 1'b1 || tx_length !== 16'd1500) begin
            n_fail++;
            $display("FAIL max_len_start: start=%b len=%0d required 1/1500", tx_start, tx_length);
        end
        tx_valid = 1'b1;
        repeat (1513) tick();
        n_tests++;
        if (done !== 4'b0000) begin
            n_fail++;
            $display("FAIL max_len_early: done=%b after 1513 bytes required 0000", done);
        end
        tick();
        tx_valid = 1'b0;
        req = 4'b0000;
        n_tests++;
        if (done !== 4'b0100 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL max_len_done: done=%b err=%b required 0100/0", done, frame_err);
        end
        wait_idle("max_len");
    endtask

    task automatic test_short_frame();
        req_len[31:16] = 16'd10;
        req = 4'b0010;
        tick();
        tick();
        tx_valid = 1'b1;
        repeat (20) tick();
        tx_valid = 1'b0;
        req = 4'b0000;
        n_tests++;
        if (done !== 4'b0000 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL short_pending: done=%b err=%b required 0000/0", done, frame_err);
        end
        tick();
        n_tests++;
        if (done !== 4'b0010 || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL short_err: done=%b err=%b required 0010/1", done, frame_err);
        end
        tick();
        n_tests++;
        if (frame_err !== 1'b0 || done !== 4'b0000) begin
            n_fail++;
            $display("FAIL short_pulse: done=%b err=%b required 0000/0", done, frame_err);
        end
        wait_idle("short");
    endtask

    task automatic test_reset_mid_xmit();
        // Last grant was requester 1; a retained pointer would favour 2 next.
        req_len[31:16] = 16'd10;
        req_len[47:32] = 16'd20;
        req = 4'b0010;
        tick();
        tick();
        tx_valid = 1'b1;
        repeat (7) tick();
        req = 4'b0110;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({gnt, gnt_idx, tx_start, tx_length, done, reject, frame_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b idx=%0d start=%b len=%0d done=%b rej=%b err=%b busy=%b required all 0",
                     gnt, gnt_idx, tx_start, tx_length, done, reject, frame_err, busy);
        end
        tx_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_ptr: gnt=%b idx=%0d required 0010/1", gnt, gnt_idx);
        end
        tick();
        tx_valid = 1'b1;
        repeat (24) tick();
        tx_valid = 1'b0;
        req = 4'b0000;
        n_tests++;
        if (done !== 4'b0010 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resume_done: done=%b err=%b required 0010/0", done, frame_err);
        end
        wait_idle("reset_resume");
    endtask

    task automatic test_timeout();
        int cnt;
        int seen;
        req_len[15:0] = 16'd10;
        req = 4'b0001;
        tick();
        tick();
        req = 4'b0000;
        n_tests++;
        if (tx_start !== 1'b1 || gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL timeout_start: start=%b gnt=%b required 1/0001", tx_start, gnt);
        end
`ifdef FRAME_TIMEOUT_EN
        cnt = 0;
        seen = 0;
        while (done === 4'b0000 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_tests++;
        if (cnt != 64 || done !== 4'b0001 || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_fire: after %0d cycles done=%b err=%b required 64/0001/1", cnt, done, frame_err);
        end
        wait_idle("timeout");
`else
        cnt = 0;
        seen = 0;
        repeat (100) begin
            tick();
            cnt++;
            if (done !== 4'b0000) seen++;
        end
        n_tests++;
        if (seen != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout: %0d done pulses in %0d cycles busy=%b required 0/1", seen, cnt, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_bad_length();
        test_short_frame();
        test_reset_mid_xmit();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
